// File: rtl/neuron_core.sv
// neuron_core: fixed-point MAC neuron with config-bus loaded weights and bias.
// Define NEURON_RELU_EN at compile time to apply ReLU after saturation.
module neuron_core #(
    parameter int layerNo        = 0,
    parameter int neuronNo       = 0,
    parameter int numWeight      = 10,
    parameter int dataWidth      = 16,
    parameter int weightIntWidth = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          config_layer_num,
    input  logic [31:0]          config_neuron_num,
    input  logic                 weightValid,
    input  logic [31:0]          weightValue,
    input  logic                 biasValid,
    input  logic [31:0]          biasValue,
    input  logic [dataWidth-1:0] myInput,
    input  logic                 myinputValid,
    output logic [dataWidth-1:0] out,
    output logic                 outvalid
);

    localparam int AW   = $clog2(numWeight);
    localparam int F    = dataWidth - weightIntWidth;
    localparam int PW   = 2 * dataWidth;
    localparam int ACCW = PW + AW;
    localparam int YW   = ACCW + 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(numWeight - 1);
    localparam logic signed [YW-1:0] SAT_MAX = {{(YW-dataWidth+1){1'b0}}, {(dataWidth-1){1'b1}}};
    localparam logic signed [YW-1:0] SAT_MIN = {{(YW-dataWidth+1){1'b1}}, {(dataWidth-1){1'b0}}};

    logic sel;
    logic weight_wr;
    logic bias_wr;

    assign sel       = (config_layer_num == 32'(layerNo)) && (config_neuron_num == 32'(neuronNo));
    assign weight_wr = weightValid & sel;
    assign bias_wr   = biasValid & sel;

    generate
        if (dataWidth < 32) begin : g_unused
            logic unused_cfg_bits;
            assign unused_cfg_bits = ^{weightValue[31:dataWidth], biasValue[31:dataWidth]};
        end
    endgenerate

    logic [dataWidth-1:0] weight_mem [numWeight];

    logic [AW-1:0]               w_addr_d, w_addr_q;
    logic [AW-1:0]               r_addr_d, r_addr_q;
    logic signed [dataWidth-1:0] bias_d, bias_q;

    // S1: RAM read, delayed sample, position tags
    logic                        s1_valid_d, s1_valid_q;
    logic                        s1_first_d, s1_first_q;
    logic                        s1_last_d, s1_last_q;
    logic signed [dataWidth-1:0] s1_weight_d, s1_weight_q;
    logic signed [dataWidth-1:0] s1_input_d, s1_input_q;

    logic                        s2_valid_d, s2_valid_q;
    logic                        s2_first_d, s2_first_q;
    logic                        s2_last_d, s2_last_q;
    logic signed [PW-1:0]        s2_prod_d, s2_prod_q;

    logic signed [ACCW-1:0]      acc_d, acc_q;
    logic                        acc_done_d, acc_done_q;

    logic signed [YW-1:0]        y_d, y_q;
    logic                        y_valid_d, y_valid_q;

    logic [dataWidth-1:0]        out_d, out_q;
    logic                        outvalid_d, outvalid_q;

    logic signed [YW-1:0]        y_shift;
    logic [dataWidth-1:0]        y_sat;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        w_addr_d = w_addr_q;
        if (weight_wr) begin
            w_addr_d = (w_addr_q == LAST_ADDR) ? '0 : w_addr_q + AW'(1);
        end
        r_addr_d = r_addr_q;
        if (myinputValid) begin
            r_addr_d = (r_addr_q == LAST_ADDR) ? '0 : r_addr_q + AW'(1);
        end
        bias_d = bias_wr ? biasValue[dataWidth-1:0] : bias_q;

        // Combinational read of the pre-edge array gives old data on a same-address write.
        s1_valid_d  = myinputValid;
        s1_first_d  = (r_addr_q == '0);
        s1_last_d   = (r_addr_q == LAST_ADDR);
        s1_weight_d = weight_mem[r_addr_q];
        s1_input_d  = myInput;

        s2_valid_d = s1_valid_q;
        s2_first_d = s1_first_q;
        s2_last_d  = s1_last_q;
        s2_prod_d  = s1_weight_q * s1_input_q;

        acc_d      = acc_q;
        acc_done_d = 1'b0;
        if (s2_valid_q) begin
            acc_d      = s2_first_q ? ACCW'(s2_prod_q) : acc_q + ACCW'(s2_prod_q);
            acc_done_d = s2_last_q;
        end

        y_valid_d = acc_done_q;
        y_d       = y_q;
        if (acc_done_q) begin
            y_d = YW'(acc_q) + (YW'(bias_q) <<< F);
        end

        y_shift = y_q >>> F;
        if (y_shift > SAT_MAX) begin
            y_sat = SAT_MAX[dataWidth-1:0];
        end else if (y_shift < SAT_MIN) begin
            y_sat = SAT_MIN[dataWidth-1:0];
        end else begin
            y_sat = y_shift[dataWidth-1:0];
        end
`ifdef NEURON_RELU_EN
        if (y_sat[dataWidth-1]) begin
            y_sat = '0;
        end
`endif
        out_d      = y_valid_q ? y_sat : out_q;
        outvalid_d = y_valid_q;
    end

    // NOTE: weight RAM and pure data stages carry no reset; only state that decides behaviour is cleared.
    always_ff @(posedge clk) begin
        if (weight_wr) begin
            weight_mem[w_addr_q] <= weightValue[dataWidth-1:0];
        end
        s1_weight_q <= s1_weight_d;
        s1_input_q  <= s1_input_d;
        s2_prod_q   <= s2_prod_d;
        y_q         <= y_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_addr_q   <= '0;
            r_addr_q   <= '0;
            bias_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_first_q <= 1'b0;
            s2_last_q  <= 1'b0;
            acc_q      <= '0;
            acc_done_q <= 1'b0;
            y_valid_q  <= 1'b0;
            out_q      <= '0;
            outvalid_q <= 1'b0;
        end else begin
            w_addr_q   <= w_addr_d;
            r_addr_q   <= r_addr_d;
            bias_q     <= bias_d;
            s1_valid_q <= s1_valid_d;
            s1_first_q <= s1_first_d;
            s1_last_q  <= s1_last_d;
            s2_valid_q <= s2_valid_d;
            s2_first_q <= s2_first_d;
            s2_last_q  <= s2_last_d;
            acc_q      <= acc_d;
            acc_done_q <= acc_done_d;
            y_valid_q  <= y_valid_d;
            out_q      <= out_d;
            outvalid_q <= outvalid_d;
        end
    end

    assign out      = out_q;
    assign outvalid = outvalid_q;

endmodule

// File: tb/tb_neuron_core.sv
// Self-checking bench for neuron_core: directed corner vectors plus randomized
// vectors scored against a plain-arithmetic reference of the neuron equation.
module tb_neuron_core;

    localparam int NW = 4;
    localparam int DW = 16;
    localparam int F  = 15;

`ifdef NEURON_RELU_EN
    localparam logic [DW-1:0] EXP_NEG     = 16'h0000;
    localparam logic [DW-1:0] EXP_NEG_SAT = 16'h0000;
`else
    localparam logic [DW-1:0] EXP_NEG     = 16'hC000;
    localparam logic [DW-1:0] EXP_NEG_SAT = 16'h8000;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   config_layer_num = '0;
    logic [31:0]   config_neuron_num = '0;
    logic          weightValid = 1'b0;
    logic [31:0]   weightValue = '0;
    logic          biasValid = 1'b0;
    logic [31:0]   biasValue = '0;
    logic [DW-1:0] myInput = '0;
    logic          myinputValid = 1'b0;
    logic [DW-1:0] dut_out;
    logic          dut_outvalid;

    neuron_core #(
        .layerNo(0), .neuronNo(0), .numWeight(NW), .dataWidth(DW), .weightIntWidth(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
        .weightValid(weightValid), .weightValue(weightValue),
        .biasValid(biasValid), .biasValue(biasValue),
        .myInput(myInput), .myinputValid(myinputValid),
        .out(dut_out), .outvalid(dut_outvalid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests_run = 0;
    int tests_failed = 0;
    int last_in_cyc = 0;

    logic [DW-1:0] got_val[$];
    int            got_cyc[$];
    always @(negedge clk) begin
        if (dut_outvalid) begin
            got_val.push_back(dut_out);
            got_cyc.push_back(cyc);
        end
    end

    // Reference model state: what the neuron should hold according to its rules.
    logic [DW-1:0] m_w[NW];
    logic [DW-1:0] m_bias = '0;
    int            m_wptr = 0;
    int            m_ridx = 0;
    longint        m_acc = 0;
    logic [DW-1:0] exp_val[$];
    int            exp_cyc[$];

    function automatic logic [DW-1:0] model_out(longint acc, logic [DW-1:0] b);
        longint y;
        y = (acc + longint'($signed(b)) * (longint'(1) <<< F)) >>> F;
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
`ifdef NEURON_RELU_EN
        if (y < 0) y = 0;
`endif
        return y[DW-1:0];
    endfunction

    task automatic idle(int n);
        repeat (n) begin
            @(negedge clk);
            weightValid = 1'b0; biasValid = 1'b0; myinputValid = 1'b0;
        end
    endtask

    task automatic clear_obs();
        got_val.delete(); got_cyc.delete();
        exp_val.delete(); exp_cyc.delete();
    endtask

    task automatic load_weight(logic [DW-1:0] v, int layer, int neuron);
        @(negedge clk);
        myinputValid = 1'b0; biasValid = 1'b0;
        weightValid = 1'b1;
        weightValue = {16'($urandom), v};
        config_layer_num = layer; config_neuron_num = neuron;
        if (layer == 0 && neuron == 0) begin
            m_w[m_wptr] = v;
            m_wptr = (m_wptr + 1) % NW;
        end
    endtask

    task automatic load_bias(logic [DW-1:0] v, int layer, int neuron);
        @(negedge clk);
        myinputValid = 1'b0; weightValid = 1'b0;
        biasValid = 1'b1;
        biasValue = {16'($urandom), v};
        config_layer_num = layer; config_neuron_num = neuron;
        if (layer == 0 && neuron == 0) m_bias = v;
    endtask

    task automatic send_sample(logic [DW-1:0] x, int gap);
        @(negedge clk);
        weightValid = 1'b0; biasValid = 1'b0;
        myinputValid = 1'b1; myInput = x;
        last_in_cyc = cyc + 1;
        m_acc += longint'($signed(m_w[m_ridx])) * longint'($signed(x));
        m_ridx++;
        if (m_ridx == NW) begin
            exp_val.push_back(model_out(m_acc, m_bias));
            exp_cyc.push_back(last_in_cyc + 4);
            m_acc = 0;
            m_ridx = 0;
        end
        if (gap > 0) idle(gap);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        weightValid = 1'b0; biasValid = 1'b0; myinputValid = 1'b0;
        m_wptr = 0; m_ridx = 0; m_acc = 0; m_bias = '0;
        exp_val.delete(); exp_cyc.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests_run++;
        if (dut_out !== 16'h0000) begin
            tests_failed++; $display("FAIL reset_out: got %h, expected 0000", dut_out);
        end
        tests_run++;
        if (dut_outvalid !== 1'b0) begin
            tests_failed++; $display("FAIL reset_outvalid: got %b, expected 0", dut_outvalid);
        end
        rst_n = 1'b1;
        idle(3);
        tests_run++;
        if (dut_outvalid !== 1'b0 || dut_out !== 16'h0000) begin
            tests_failed++; $display("FAIL post_reset_idle: got %b/%h, expected 0/0000", dut_outvalid, dut_out);
        end
    endtask

    task automatic test_basic();
        clear_obs();
        for (int i = 0; i < NW; i++) load_weight(16'h4000, 0, 0);
        load_bias(16'h0000, 0, 0);
        for (int i = 0; i < NW; i++) send_sample(16'h2000, 0);
        idle(8);
        tests_run++;
        if (got_val.size() != 1) begin
            tests_failed++; $display("FAIL basic_strobes: got %0d, expected 1", got_val.size());
        end
        tests_run++;
        if (got_val.size() == 0 || got_val[0] !== 16'h4000) begin
            tests_failed++; $display("FAIL basic_value: got %h, expected 4000", got_val.size() ? got_val[0] : 16'hxxxx);
        end
        tests_run++;
        if (got_cyc.size() == 0 || got_cyc[0] != last_in_cyc + 4) begin
            tests_failed++; $display("FAIL basic_latency: got cycle %0d, expected %0d", got_cyc.size() ? got_cyc[0] : -1, last_in_cyc + 4);
        end
        tests_run++;
        if (dut_out !== 16'h4000) begin
            tests_failed++; $display("FAIL basic_hold: got %h, expected 4000", dut_out);
        end
    endtask

    task automatic test_gaps_back_to_back();
        clear_obs();
        load_bias(16'h1000, 0, 0);
        for (int i = 0; i < NW; i++) send_sample(16'h2000, (i < NW - 1) ? 1 : 0);
        for (int i = 0; i < NW; i++) send_sample(16'h0000, 0);
        idle(8);
        tests_run++;
        if (got_val.size() != 2) begin
            tests_failed++; $display("FAIL gaps_strobes: got %0d, expected 2", got_val.size());
        end
        tests_run++;
        if (got_val.size() < 2 || got_val[0] !== 16'h5000 || got_val[1] !== 16'h1000) begin
            tests_failed++;
            $display("FAIL gaps_values: got %h %h, expected 5000 1000",
                     got_val.size() > 0 ? got_val[0] : 16'hxxxx, got_val.size() > 1 ? got_val[1] : 16'hxxxx);
        end
        tests_run++;
        if (got_cyc.size() < 2 || got_cyc[1] != last_in_cyc + 4) begin
            tests_failed++; $display("FAIL gaps_latency: got cycle %0d, expected %0d", got_cyc.size() > 1 ? got_cyc[1] : -1, last_in_cyc + 4);
        end
    endtask

    task automatic test_negative();
        clear_obs();
        for (int i = 0; i < NW; i++) load_weight(16'hC000, 0, 0);
        load_bias(16'h0000, 0, 0);
        for (int i = 0; i < NW; i++) send_sample(16'h2000, 0);
        idle(8);
        tests_run++;
        if (got_val.size() != 1 || got_val[0] !== EXP_NEG) begin
            tests_failed++; $display("FAIL negative_value: got %h (%0d strobes), expected %h", got_val.size() ? got_val[0] : 16'hxxxx, got_val.size(), EXP_NEG);
        end
    endtask

    task automatic test_saturation();
        clear_obs();
        for (int i = 0; i < NW; i++) load_weight(16'h7FFF, 0, 0);
        for (int i = 0; i < NW; i++) send_sample(16'h7FFF, 0);
        idle(8);
        for (int i = 0; i < NW; i++) load_weight(16'h8000, 0, 0);
        for (int i = 0; i < NW; i++) send_sample(16'h7FFF, 0);
        idle(8);
        tests_run++;
        if (got_val.size() < 1 || got_val[0] !== 16'h7FFF) begin
            tests_failed++; $display("FAIL sat_positive: got %h, expected 7fff", got_val.size() ? got_val[0] : 16'hxxxx);
        end
        tests_run++;
        if (got_val.size() < 2 || got_val[1] !== EXP_NEG_SAT) begin
            tests_failed++; $display("FAIL sat_negative: got %h, expected %h", got_val.size() > 1 ? got_val[1] : 16'hxxxx, EXP_NEG_SAT);
        end
    endtask

    task automatic test_select();
        clear_obs();
        for (int i = 0; i < NW; i++) load_weight(16'h2000, 0, 0);
        load_bias(16'h0800, 0, 0);
        for (int i = 0; i < NW; i++) send_sample(16'h4000, 0);
        for (int i = 0; i < NW; i++) load_weight(16'h1234, 0, 1);
        load_bias(16'h7000, 0, 1);
        for (int i = 0; i < NW; i++) load_weight(16'h7FFF, 1, 0);
        load_bias(16'h0100, 1, 0);
        for (int i = 0; i < NW; i++) send_sample(16'h4000, 0);
        idle(8);
        tests_run++;
        if (got_val.size() != 2 || got_val[0] !== 16'h4800 || got_val[1] !== 16'h4800) begin
            tests_failed++;
            $display("FAIL select_ignored: got %h %h (%0d strobes), expected 4800 4800",
                     got_val.size() > 0 ? got_val[0] : 16'hxxxx, got_val.size() > 1 ? got_val[1] : 16'hxxxx, got_val.size());
        end
    endtask

    task automatic test_mid_reset();
        clear_obs();
        for (int i = 0; i < NW; i++) load_weight(16'h4000, 0, 0);
        load_bias(16'h0000, 0, 0);
        send_sample(16'h2000, 0);
        send_sample(16'h2000, 0);
        do_reset();
        idle(6);
        tests_run++;
        if (got_val.size() != 0) begin
            tests_failed++; $display("FAIL midreset_no_strobe: got %0d strobes, expected 0", got_val.size());
        end
        tests_run++;
        if (dut_out !== 16'h0000) begin
            tests_failed++; $display("FAIL midreset_out: got %h, expected 0000", dut_out);
        end
        for (int i = 0; i < NW; i++) send_sample(16'h2000, 0);
        idle(8);
        tests_run++;
        if (got_val.size() != 1 || got_val[0] !== 16'h4000) begin
            tests_failed++; $display("FAIL midreset_retained: got %h (%0d strobes), expected 4000", got_val.size() ? got_val[0] : 16'hxxxx, got_val.size());
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] x;
        clear_obs();
        for (int v = 0; v < 12; v++) begin
            if (v % 3 == 0) begin
                for (int i = 0; i < NW; i++) load_weight(16'($urandom), 0, (v == 6) ? 1 : 0);
                load_bias(16'($urandom_range(0, 16383)) - 16'h2000, 0, 0);
            end
            for (int i = 0; i < NW; i++) begin
                x = (v % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 16383)) - 16'h2000;
                send_sample(x, $urandom_range(0, 2));
            end
        end
        idle(8);
        tests_run++;
        if (got_val.size() != exp_val.size()) begin
            tests_failed++; $display("FAIL random_strobes: got %0d, expected %0d", got_val.size(), exp_val.size());
        end
        for (int i = 0; i < exp_val.size() && i < got_val.size(); i++) begin
            tests_run++;
            if (got_val[i] !== exp_val[i] || got_cyc[i] != exp_cyc[i]) begin
                tests_failed++;
                $display("FAIL random_vec%0d: got %h at cycle %0d, expected %h at cycle %0d",
                         i, got_val[i], got_cyc[i], exp_val[i], exp_cyc[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps_back_to_back();
        test_negative();
        test_saturation();
        test_select();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
